// File: rtl/cpu_boot_loader.sv
// cpu_boot_loader: byte-stream boot loader for integrated_cpu.
// Receives a little-endian frame {CNT[15:0], PC[15:0], DATA[N*4], CHK[7:0]},
// writes each assembled word into the CPU memory write port, and holds the CPU
// in reset until the frame checksum matches. A good load then releases the CPU
// at the loaded start PC.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   start                 single-cycle pulse, begins a load from IDLE/DONE/ERR
//   byte_in, byte_valid   stream byte and its valid flag
//   byte_ready            loader accepts byte_in this cycle
//   mem_wr_en/addr/data   memory write port, one strobe cycle per word
//   cpu_rst_n, start_pc   CPU reset (active low) and start PC
//   busy, done, err       load status
module cpu_boot_loader #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wr_data,
    output logic              cpu_rst_n,
    output logic [10:0]       start_pc,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // One extra index bit so a full-depth load reaches N without wrapping.
    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam int unsigned PC_W  = 11;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT,
        S_PC,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        buf_q, buf_d;
    logic [7:0]         chk_q, chk_d;

    logic               byte_ready_d;
    logic               mem_wr_en_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [31:0]        mem_wr_data_d;
    logic               cpu_rst_n_d;
    logic [PC_W-1:0]    start_pc_d;
    logic               busy_d;
    logic               done_d;
    logic               err_d;

    logic               xfer;
    logic [CNT_W-1:0]   cnt_full;

    assign xfer     = byte_valid & byte_ready;
    assign cnt_full = {byte_in, cnt_q[7:0]};

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            byte_idx_q  <= '0;
            word_idx_q  <= '0;
            cnt_q       <= '0;
            buf_q       <= '0;
            chk_q       <= '0;
            byte_ready  <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            cpu_rst_n   <= 1'b0;
            start_pc    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            word_idx_q  <= word_idx_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            chk_q       <= chk_d;
            byte_ready  <= byte_ready_d;
            mem_wr_en   <= mem_wr_en_d;
            mem_addr    <= mem_addr_d;
            mem_wr_data <= mem_wr_data_d;
            cpu_rst_n   <= cpu_rst_n_d;
            start_pc    <= start_pc_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
        end
    end

    // Next-state, datapath update and next-output decode.
    always_comb begin
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        word_idx_d    = word_idx_q;
        cnt_d         = cnt_q;
        buf_d         = buf_q;
        chk_d         = chk_q;
        mem_wr_en_d   = 1'b0;
        mem_addr_d    = mem_addr;
        mem_wr_data_d = mem_wr_data;
        start_pc_d    = start_pc;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_CNT;
                    byte_idx_d = '0;
                    word_idx_d = '0;
                    cnt_d      = '0;
                    chk_d      = '0;
                end
            end

            S_CNT: begin
                if (xfer) begin
                    if (byte_idx_q == 2'd0) begin
                        cnt_d[7:0] = byte_in;
                        byte_idx_d = 2'd1;
                    end else begin
                        cnt_d[15:8] = byte_in;
                        byte_idx_d  = 2'd0;
                        state_d     = (cnt_full > CNT_W'(DEPTH)) ? S_ERR : S_PC;
                    end
                end
            end

            S_PC: begin
                // Low PC byte parks in the word buffer; data bytes overwrite it later.
                if (xfer) begin
                    if (byte_idx_q == 2'd0) begin
                        buf_d[7:0] = byte_in;
                        byte_idx_d = 2'd1;
                    end else begin
                        start_pc_d = PC_W'({byte_in, buf_q[7:0]});
                        byte_idx_d = 2'd0;
                        state_d    = (cnt_q == '0) ? S_CHK : S_DATA;
                    end
                end
            end

            S_DATA: begin
                // Little-endian shift: after 4 bytes, byte 0 sits in bits [7:0].
                if (xfer) begin
                    buf_d      = {byte_in, buf_q[31:8]};
                    chk_d      = chk_q ^ byte_in;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d       = S_WRITE;
                        mem_wr_en_d   = 1'b1;
                        mem_addr_d    = word_idx_q[ADDR_W-1:0];
                        mem_wr_data_d = {byte_in, buf_q[31:8]};
                    end
                end
            end

            S_WRITE: begin
                word_idx_d = word_idx_q + IDX_W'(1);
                state_d    = (word_idx_d == IDX_W'(cnt_q)) ? S_CHK : S_DATA;
            end

            S_CHK: begin
                if (xfer) begin
                    state_d = (byte_in == chk_q) ? S_DONE : S_ERR;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Status outputs follow the state being entered so they are valid on its first cycle.
        byte_ready_d = (state_d == S_CNT) || (state_d == S_PC) ||
                       (state_d == S_DATA) || (state_d == S_CHK);
        busy_d       = byte_ready_d || (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
        err_d        = (state_d == S_ERR);
        cpu_rst_n_d  = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Self-checking bench for cpu_boot_loader: directed frame table, hand-written
// corner sequences, and randomized frames checked against a frame-level model.
module tb_cpu_boot_loader;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DEPTH  = 2048;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wr_data;
    logic              cpu_rst_n;
    logic [10:0]       start_pc;
    logic              busy;
    logic              done;
    logic              err;

    cpu_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wr_data(mem_wr_data),
        .cpu_rst_n  (cpu_rst_n),
        .start_pc   (start_pc),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]       words [0:DEPTH-1];
    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [31:0]       wr_data_q [$];
    logic              prev_wr = 1'b0;
    logic [10:0]       model_pc = 11'h000;

    typedef struct {
        logic [15:0] n;
        logic [15:0] pc;
        logic [7:0]  chk;
        int          gap;
        logic        exp_done;
        logic        exp_err;
        logic [10:0] exp_pc;
        int          exp_nwr;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Write-port monitor: collect writes, each strobe exactly one cycle with the stream stalled.
    always @(negedge clk) begin
        if (mem_wr_en) begin
            check("wr_pulse_single", 32'(prev_wr), 32'(0));
            check("ready_low_in_write", 32'(byte_ready), 32'(0));
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wr_data);
        end
        prev_wr = mem_wr_en;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        for (int t = 0; t < 64 && !ok; t++) begin
            if (byte_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_accept: byte 0x%0h not accepted, actual timeout required accept within 64 cycles", b);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_load(input logic [15:0] n, input logic [15:0] pc, input logic [7:0] chk, input int gap);
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(n[7:0], gap);
        send_byte(n[15:8], gap);
        if (32'(n) <= DEPTH) begin
            send_byte(pc[7:0], gap);
            send_byte(pc[15:8], gap);
            for (int i = 0; i < int'(n); i++) begin
                for (int k = 0; k < 4; k++) begin
                    send_byte(words[i][8*k +: 8], gap);
                end
            end
            send_byte(chk, gap);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic check_load(input string tag, input logic ed, input logic ee,
                              input logic [10:0] ep, input int enw);
        check({tag, ".done"},      32'(done),       32'(ed));
        check({tag, ".err"},       32'(err),        32'(ee));
        check({tag, ".cpu_rst_n"}, 32'(cpu_rst_n),  32'(ed));
        check({tag, ".busy"},      32'(busy),       32'(0));
        check({tag, ".byte_ready"},32'(byte_ready), 32'(0));
        check({tag, ".start_pc"},  32'(start_pc),   32'(ep));
        check({tag, ".nwr"},       32'(wr_addr_q.size()), 32'(enw));
        for (int i = 0; i < wr_addr_q.size() && i < enw; i++) begin
            check({tag, ".wr_addr"}, 32'(wr_addr_q[i]), 32'(i));
            check({tag, ".wr_data"}, wr_data_q[i], words[i]);
        end
        model_pc = ep;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".byte_ready"},  32'(byte_ready),  32'(0));
        check({tag, ".mem_wr_en"},   32'(mem_wr_en),   32'(0));
        check({tag, ".mem_addr"},    32'(mem_addr),    32'(0));
        check({tag, ".mem_wr_data"}, mem_wr_data,      32'(0));
        check({tag, ".cpu_rst_n"},   32'(cpu_rst_n),   32'(0));
        check({tag, ".start_pc"},    32'(start_pc),    32'(0));
        check({tag, ".busy"},        32'(busy),        32'(0));
        check({tag, ".done"},        32'(done),        32'(0));
        check({tag, ".err"},         32'(err),         32'(0));
    endtask

    function automatic logic [7:0] frame_xor(input int n);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            x = x ^ words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
        end
        return x;
    endfunction

    // Frame-level reference: writes happen whenever N fits; completion needs a matching checksum.
    task automatic random_load(input string tag, input logic [15:0] n, input int gap);
        logic [15:0] pc;
        logic [7:0]  x;
        logic [7:0]  chk;
        logic        fits;
        logic [10:0] ep;
        pc   = 16'($urandom);
        fits = (32'(n) <= DEPTH);
        if (fits) begin
            for (int i = 0; i < int'(n); i++) words[i] = $urandom;
        end
        x   = fits ? frame_xor(int'(n)) : 8'h00;
        chk = ($urandom_range(0, 1) == 0) ? x : (x ^ 8'($urandom_range(1, 255)));
        ep  = fits ? pc[10:0] : model_pc;
        run_load(n, pc, chk, gap);
        check_load(tag, fits && (chk == x), !(fits && (chk == x)), ep, fits ? int'(n) : 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{16'd2,     16'h0004, 8'h2A, 0, 1'b1, 1'b0, 11'h004, 2};
        vecs[1] = '{16'd2,     16'h0004, 8'h01, 0, 1'b0, 1'b1, 11'h004, 2};
        vecs[2] = '{16'd2,     16'h0004, 8'h00, 0, 1'b0, 1'b1, 11'h004, 2};
        vecs[3] = '{16'd0,     16'hFFFF, 8'h00, 1, 1'b1, 1'b0, 11'h7FF, 0};
        vecs[4] = '{16'd0,     16'h0123, 8'h05, 0, 1'b0, 1'b1, 11'h123, 0};
        vecs[5] = '{16'd1,     16'hF800, 8'h22, 1, 1'b1, 1'b0, 11'h000, 1};
        vecs[6] = '{16'h0801,  16'h0ABC, 8'h00, 0, 1'b0, 1'b1, 11'h000, 0};
        vecs[7] = '{16'hFFFF,  16'h0000, 8'h00, 0, 1'b0, 1'b1, 11'h000, 0};

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        // Directed frame table.
        words[0] = 32'hDEADBEEF;
        words[1] = 32'h12345678;
        for (int r = 0; r < 8; r++) begin
            run_load(vecs[r].n, vecs[r].pc, vecs[r].chk, vecs[r].gap);
            check_load($sformatf("vec%0d", r), vecs[r].exp_done, vecs[r].exp_err,
                       vecs[r].exp_pc, vecs[r].exp_nwr);
        end

        // Oversize count: stream stalls right after the second count byte.
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h08, 0);
        byte_in = 8'h55;
        repeat (4) begin
            @(negedge clk);
            check("oversize.err", 32'(err), 32'(1));
            check("oversize.byte_ready", 32'(byte_ready), 32'(0));
        end
        byte_valid = 1'b0;
        check("oversize.nwr", 32'(wr_addr_q.size()), 32'(0));

        // Mid-load reset after the third data byte, then a clean reload.
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hAD, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        check("midrst.busy_before", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst.nwr", 32'(wr_addr_q.size()), 32'(0));
        run_load(16'd2, 16'h0004, 8'h2A, 0);
        check_load("reload", 1'b1, 1'b0, 11'h004, 2);

        // Start pulse in DONE: CPU goes back into reset on the next edge.
        pulse_start();
        check("restart.cpu_rst_n",  32'(cpu_rst_n),  32'(0));
        check("restart.done",       32'(done),       32'(0));
        check("restart.err",        32'(err),        32'(0));
        check("restart.busy",       32'(busy),       32'(1));
        check("restart.byte_ready", 32'(byte_ready), 32'(1));
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int i = 0; i < 5; i++) send_byte(8'h00, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        check_load("restart", 1'b1, 1'b0, 11'h000, 0);

        // Randomized frames against the reference model.
        for (int it = 0; it < 12; it++) begin
            logic [15:0] n;
            n = 16'($urandom_range(0, 12));
            if ($urandom_range(0, 4) == 0) n = 16'(DEPTH + 1 + $urandom_range(0, 1000));
            random_load($sformatf("rand%0d", it), n, $urandom_range(0, 2));
        end

        // Full-depth load: last address DEPTH-1, no index wrap.
        random_load("full_depth", 16'(DEPTH), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
